// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial transmitter: state encoding, line idle
// level and the frame-length helper.
package serial_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_START  = ST_START,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP
    } state_e;

    localparam logic TXD_IDLE = 1'b1;

    // Cycles from accept edge to end of stop bit.
    function automatic int frame_len(input int data_w, input int clks_per_bit, input bit parity);
        return (data_w + 2 + (parity ? 1 : 0)) * clks_per_bit;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Parallel-load handshake plus serial line outputs of serial_tx.
interface serial_tx_if #(parameter int DATA_W = 8);
    logic [DATA_W-1:0] D;
    logic              LOAD;
    logic              RDY;
    logic              TXD;
    logic              BUSY;

    modport master (output D, output LOAD, input RDY, input TXD, input BUSY);
    modport slave  (input D, input LOAD, output RDY, output TXD, output BUSY);
endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 while enabled, pulses
// o_bit_done on the terminal count, and restarts on i_restart.
module bit_timer #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_restart,
    output logic o_bit_done
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_bit_done = i_en && (r_cnt == LAST);

    always_ff @(posedge i_clk) begin
        if (i_clr || i_restart || !i_en || o_bit_done)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/serial_tx.sv
// Serial transmitter: start, DATA_W bits LSB first, optional even parity
// (SERIAL_TX_PARITY_EN), stop. Each bit held CLKS_PER_BIT cycles.
module serial_tx
    import serial_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input logic       CLK,
    input logic       CLR,
    serial_tx_if.slave bus
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    state_e            r_state, w_state_nxt;
    logic [DATA_W-1:0] r_shift, w_shift_nxt;
    logic [IDX_W-1:0]  r_idx, w_idx_nxt;
    logic              r_txd, w_txd_nxt;
    logic              w_bit_done, w_accept, w_rdy;
`ifdef SERIAL_TX_PARITY_EN
    logic              r_par, w_par_nxt;
`endif

    bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .i_clk      (CLK),
        .i_clr      (CLR),
        .i_en       (r_state != S_IDLE),
        .i_restart  (w_accept),
        .o_bit_done (w_bit_done)
    );

    // RDY comes from registered state/count only, never from LOAD.
    assign w_rdy    = (r_state == S_IDLE) || (r_state == S_STOP && w_bit_done);
    assign w_accept = bus.LOAD && w_rdy;

    assign bus.RDY  = w_rdy;
    assign bus.BUSY = (r_state != S_IDLE);
    assign bus.TXD  = r_txd;

    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_idx_nxt   = r_idx;
`ifdef SERIAL_TX_PARITY_EN
        w_par_nxt   = w_accept ? ^bus.D : r_par;
`endif
        unique case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_nxt = S_START;
                w_shift_nxt = bus.D;
            end
            S_START: if (w_bit_done) begin
                w_state_nxt = S_DATA;
                w_idx_nxt   = '0;
            end
            S_DATA: if (w_bit_done) begin
                w_shift_nxt = r_shift >> 1;
                if (r_idx == IDX_LAST) begin
                    w_idx_nxt = '0;
`ifdef SERIAL_TX_PARITY_EN
                    w_state_nxt = S_PARITY;
`else
                    w_state_nxt = S_STOP;
`endif
                end else begin
                    w_idx_nxt = r_idx + 1'b1;
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: if (w_bit_done) w_state_nxt = S_STOP;
`endif
            S_STOP: if (w_bit_done) begin
                if (w_accept) begin
                    w_state_nxt = S_START;
                    w_shift_nxt = bus.D;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Line level is derived from the next state so TXD is a clean flop output.
        w_txd_nxt = TXD_IDLE;
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
`ifdef SERIAL_TX_PARITY_EN
            S_PARITY: w_txd_nxt = w_par_nxt;
`endif
            default:  w_txd_nxt = TXD_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_txd   <= TXD_IDLE;
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_idx   <= w_idx_nxt;
            r_txd   <= w_txd_nxt;
`ifdef SERIAL_TX_PARITY_EN
            r_par   <= w_par_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: directed scenarios plus random traffic, every cycle
// compared against a frame-position reference model.
module tb_serial_tx;
    import serial_tx_pkg::*;

    localparam int DW = 8;
    localparam int C  = 4;
`ifdef SERIAL_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int F = frame_len(DW, C, PAR);

    logic CLK = 1'b0;
    logic CLR = 1'b1;
    serial_tx_if #(.DATA_W(DW)) bus ();

    serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(C)) dut (
        .CLK (CLK),
        .CLR (CLR),
        .bus (bus.slave)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_err = 0;

    // Model: idle, or k cycles into a frame carrying m_word.
    bit          m_act  = 1'b0;
    int          m_k    = 0;
    logic [DW-1:0] m_word = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int b;
        if (!m_act) return 1'b1;
        b = m_k / C;
        if (b == 0) return 1'b0;
        if (b <= DW) return m_word[b-1];
        if (PAR && b == DW + 1) return ^m_word;
        return 1'b1;
    endfunction

    function automatic logic exp_rdy();
        return !m_act || (m_k == F - 1);
    endfunction

    task automatic step(input logic clr, input logic load, input logic [DW-1:0] d);
        logic rdy_pre;
        CLR      = clr;
        bus.LOAD = load;
        bus.D    = d;
        rdy_pre  = exp_rdy();
        @(posedge CLK);
        if (clr) m_act = 1'b0;
        else if (load && rdy_pre) begin
            m_act = 1'b1; m_k = 0; m_word = d;
        end else if (m_act) begin
            m_k++;
            if (m_k == F) m_act = 1'b0;
        end
        @(negedge CLK);
        chk("txd",  {31'd0, bus.TXD},  {31'd0, exp_txd()});
        chk("rdy",  {31'd0, bus.RDY},  {31'd0, exp_rdy()});
        chk("busy", {31'd0, bus.BUSY}, {31'd0, m_act});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0);
    endtask

    initial begin
        int busy_cnt;
        bus.LOAD = 1'b0;
        bus.D    = '0;

        // Reset with LOAD/D=FF presented: nothing may start.
        step(1'b1, 1'b1, 8'hFF);
        step(1'b1, 1'b1, 8'hFF);
        idle(6);

        // Single frame, count BUSY cycles.
        step(1'b0, 1'b1, 8'hA5);
        busy_cnt = 1;
        for (int i = 0; i < F + 3; i++) begin
            step(1'b0, 1'b0, 8'h00);
            if (bus.BUSY) busy_cnt++;
        end
        chk("frame_len", busy_cnt, F);

        // Back-to-back with LOAD held: two contiguous frames.
        for (int i = 0; i < 2 * F; i++) step(1'b0, 1'b1, (i == 0) ? 8'h01 : 8'h80);
        idle(4);

        // Load while busy is ignored.
        step(1'b0, 1'b1, 8'h3C);
        for (int i = 1; i < F + 4; i++) step(1'b0, (i > C && i < 5 * C), 8'hFF);

        // Abort during data bit 3, then a clean frame.
        step(1'b0, 1'b1, 8'h55);
        idle(4 * C);
        step(1'b1, 1'b0, 8'h00);
        chk("abort_txd", {31'd0, bus.TXD}, 32'd1);
        chk("abort_rdy", {31'd0, bus.RDY}, 32'd1);
        step(1'b0, 1'b1, 8'hC3);
        idle(F + 2);

        // Parity-relevant words.
        step(1'b0, 1'b1, 8'h07);
        idle(F);
        step(1'b0, 1'b1, 8'hA5);
        idle(F);

        // Random traffic with occasional clears.
        for (int i = 0; i < 600; i++)
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) == 0), DW'($urandom));
        idle(F + 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/serial_tx.md
# serial_tx

Parameterized serial transmitter that accepts a parallel word through a valid/ready handshake and shifts it out on a single line. Each frame is a start bit, DATA_W data bits sent LSB first, an optional even-parity bit, and a stop bit. Every bit is held for CLKS_PER_BIT clock cycles. The block is the driving end of the single-wire serial link, and its output feeds the lab's latch- and register-based capture stages.

## Interface
- DATA_W, 8, width of the parallel data word (≥2)
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (≥1)
- CLK  input  1  clock; all state updates on the rising edge
- CLR  input  1  reset, synchronous and active-high; one clock, no other clock or reset in the block
- D  input  DATA_W  parallel word to transmit
- LOAD  input  1  request: D is valid
- RDY  output  1  block can accept a word at this edge
- TXD  output  1  serial line; idles high
- BUSY  output  1  a frame is in progress

## Operation
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Reset values: state=IDLE, TXD=1, RDY=1, BUSY=0, bit-time counter=0, bit index=0, shift register=0.
- Accept: a rising edge with LOAD=1 and RDY=1 captures D into the shift register and moves to START. LOAD while RDY=0 is ignored; there is no queue. D changes after capture have no effect.
- START: TXD=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: TXD=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment the index. After bit DATA_W-1, go to PARITY, or to STOP when the macro is off.
- PARITY: TXD=^captured word for CLKS_PER_BIT cycles, then go to STOP.
- STOP: TXD=1 for CLKS_PER_BIT cycles, then go to IDLE, or straight to START if a word is accepted on that edge.
- RDY = (state==IDLE) or (state==STOP and bit-time counter==CLKS_PER_BIT-1). RDY is decoded from registers only and has no combinational path from LOAD.
- BUSY = (state!=IDLE).
- TXD is registered and glitch-free.
- Bit-time counter width is $clog2(CLKS_PER_BIT) with a minimum of 1. Bit index width is $clog2(DATA_W). Both wrap to 0 at the end of each bit or frame.

## Timing
- Frame length F = (DATA_W+2)·CLKS_PER_BIT cycles, or (DATA_W+3)·CLKS_PER_BIT with parity.
- If the word is accepted at edge e0, TXD=0 starting from e0. The stop bit ends at edge e0+F.
- Back-to-back: LOAD=1 in the last stop cycle is accepted at e0+F. The next start bit begins at that edge with zero idle cycles.
- CLKS_PER_BIT=1 gives one bit per cycle. In that case RDY is high for the whole single STOP cycle.
- CLR has priority over LOAD at the same edge, and the word presented at that edge is dropped.
- CLR mid-frame aborts the frame: TXD=1, RDY=1, BUSY=0 from the next cycle. A partial frame is not completed.

## Configuration
- SERIAL_TX_PARITY_EN defined: the PARITY state is compiled in and one even-parity bit is inserted between the data and stop bits. The total count of ones across data and parity is even.
- SERIAL_TX_PARITY_EN undefined: the PARITY state and its logic are absent. The frame is start, data, stop, and F drops by CLKS_PER_BIT.

## Structure
- Package serial_tx_pkg holds:
  - state encoding localparams (IDLE=0, START=1, DATA=2, PARITY=3, STOP=4)
  - TXD idle level constant (1'b1)
  - frame-length function taking DATA_W, CLKS_PER_BIT and the parity flag
- One sub-module, bit_timer:
  - counts 0..CLKS_PER_BIT-1 with a synchronous clear
  - asserts a one-cycle bit_done on the terminal count
  - restarts at each accept
- FSM, shift register and parity logic stay in serial_tx.

## Test plan
- Reset: hold CLR=1 for 2 cycles with LOAD=1, D=8'hFF → TXD=1, RDY=1, BUSY=0, and no frame starts after release.
- Single frame, DATA_W=8, CLKS_PER_BIT=4, no parity, D=8'hA5 → TXD = 0, 1,0,1,0,0,1,0,1, 1, each held 4 cycles. BUSY high for 40 cycles. RDY returns in cycle 40.
- Back-to-back: 8'h01 then 8'h80 with LOAD held high → 80 contiguous cycles with no idle gap. The second start bit follows the first stop bit directly.
- Busy load: load 8'h3C, then LOAD=1 with D=8'hFF during the data bits → only 8'h3C is transmitted, and TXD idles high afterwards.
- Abort: CLR=1 during data bit 3 of 8'h55 → TXD=1, RDY=1 the next cycle. A following load of 8'hC3 produces a clean 40-cycle frame.
- Parity (macro defined): 8'h07 → parity bit 1, frame 44 cycles. 8'hA5 → parity bit 0.
